// File: rtl/pc88_loader_sink_if.sv
// Loader byte-stream and SDRAM write-port signals of pc88_loader_sink.
// The slave modport is the sink's view; the master modport is the sender/arbiter side.
interface pc88_loader_sink_if #(
    parameter int unsigned AW = 19
);
    logic          ldr_oe;
    logic [AW-1:0] ldr_adr;
    logic [7:0]    ldr_wdat;
    logic          ldr_wr;
    logic          ldr_ack;
    logic          ldr_done;

    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic          mem_ack;

    modport slave (
        input  ldr_oe, ldr_adr, ldr_wdat, ldr_wr, mem_ack,
        output ldr_ack, ldr_done, mem_req, mem_addr, mem_din, mem_be
    );

    modport master (
        output ldr_oe, ldr_adr, ldr_wdat, ldr_wr, mem_ack,
        input  ldr_ack, ldr_done, mem_req, mem_addr, mem_din, mem_be
    );
endinterface

// File: rtl/pc88_loader_sink.sv
// PC-8801 loader responder: packs loader bytes into little-endian 16-bit SDRAM writes.
// Define LOADER_CHECKSUM_EN to build the running byte checksum on `sum`.
module pc88_loader_sink #(
    parameter int unsigned   AW         = 19,
    parameter logic [AW-2:0] BASE_WADDR = '0
) (
    input  logic               clk_sys,
    input  logic               reset,
    pc88_loader_sink_if.slave  bus,
    output logic               busy,
    output logic [15:0]        sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_ACK,
        S_WAITLOW,
        S_FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_oe_q;
    logic          r_fall_pend;
    logic          r_armed;
    logic          r_hold_vld;
    logic [7:0]    r_hold_data;
    logic [AW-2:0] r_hold_waddr;
    logic          r_is_flush;
    logic          r_ack;
    logic          r_done;
    logic          r_mem_req;
    logic [AW-2:0] r_mem_addr;
    logic [15:0]   r_mem_din;
    logic [1:0]    r_mem_be;

    logic          w_oe_fall;
    logic          w_end;
    logic          w_take;
    logic [AW-2:0] w_waddr;

    logic          w_hold_load;
    logic          w_hold_clr;
    logic          w_issue;
    logic          w_issue_flush;
    logic [AW-2:0] w_issue_addr;
    logic [15:0]   w_issue_din;
    logic [1:0]    w_issue_be;
    logic          w_req_drop;
    logic          w_ack_set;
    logic          w_done_set;
    logic          w_fall_clr;
    logic          w_arm_clr;
    logic          w_arm_set;

    assign w_oe_fall = r_oe_q & ~bus.ldr_oe;
    assign w_end     = w_oe_fall | r_fall_pend;
    assign w_take    = bus.ldr_wr & bus.ldr_oe & r_armed;
    assign w_waddr   = bus.ldr_adr[AW-1:1] + BASE_WADDR;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_hold_load   = 1'b0;
        w_hold_clr    = 1'b0;
        w_issue       = 1'b0;
        w_issue_flush = 1'b0;
        w_issue_addr  = '0;
        w_issue_din   = '0;
        w_issue_be    = '0;
        w_req_drop    = 1'b0;
        w_ack_set     = 1'b0;
        w_done_set    = 1'b0;
        w_fall_clr    = 1'b0;
        w_arm_clr     = 1'b0;
        w_arm_set     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_end) begin
                    w_fall_clr = 1'b1;
                    if (r_hold_vld) begin
                        w_issue      = 1'b1;
                        w_issue_addr = r_hold_waddr;
                        w_issue_din  = {8'h00, r_hold_data};
                        w_issue_be   = 2'b01;
                        w_hold_clr   = 1'b1;
                        w_state_nxt  = S_FLUSH;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end else if (w_take) begin
                    if (!bus.ldr_adr[0] && !r_hold_vld) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_ACK;
                    end else if (bus.ldr_adr[0] && r_hold_vld && (r_hold_waddr == w_waddr)) begin
                        w_issue      = 1'b1;
                        w_issue_addr = w_waddr;
                        w_issue_din  = {bus.ldr_wdat, r_hold_data};
                        w_issue_be   = 2'b11;
                        w_hold_clr   = 1'b1;
                        w_state_nxt  = S_WRITE;
                    end else if (r_hold_vld) begin
                        // Orphaned even byte goes out alone; the current byte stays un-acked.
                        w_issue       = 1'b1;
                        w_issue_flush = 1'b1;
                        w_issue_addr  = r_hold_waddr;
                        w_issue_din   = {8'h00, r_hold_data};
                        w_issue_be    = 2'b01;
                        w_hold_clr    = 1'b1;
                        w_state_nxt   = S_WRITE;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_addr = w_waddr;
                        w_issue_din  = {bus.ldr_wdat, 8'h00};
                        w_issue_be   = 2'b10;
                        w_state_nxt  = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.mem_ack) begin
                    w_req_drop  = 1'b1;
                    w_state_nxt = r_is_flush ? S_IDLE : S_ACK;
                end
            end
            S_FLUSH: begin
                if (bus.mem_ack) begin
                    w_req_drop  = 1'b1;
                    w_done_set  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                w_ack_set   = 1'b1;
                w_arm_clr   = 1'b1;
                w_state_nxt = S_WAITLOW;
            end
            S_WAITLOW: begin
                if (!bus.ldr_wr) begin
                    w_arm_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_oe_q       <= 1'b0;
            r_fall_pend  <= 1'b0;
            r_armed      <= 1'b1;
            r_hold_vld   <= 1'b0;
            r_hold_data  <= '0;
            r_hold_waddr <= '0;
            r_is_flush   <= 1'b0;
            r_ack        <= 1'b0;
            r_done       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_be     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_oe_q  <= bus.ldr_oe;
            r_ack   <= w_ack_set;
            r_done  <= w_done_set;

            if (w_fall_clr)     r_fall_pend <= 1'b0;
            else if (w_oe_fall) r_fall_pend <= 1'b1;

            if (w_arm_clr)      r_armed <= 1'b0;
            else if (w_arm_set) r_armed <= 1'b1;

            if (w_hold_load) begin
                r_hold_vld   <= 1'b1;
                r_hold_data  <= bus.ldr_wdat;
                r_hold_waddr <= w_waddr;
            end else if (w_hold_clr) begin
                r_hold_vld   <= 1'b0;
            end

            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_issue_addr;
                r_mem_din  <= w_issue_din;
                r_mem_be   <= w_issue_be;
                r_is_flush <= w_issue_flush;
            end else if (w_req_drop) begin
                r_mem_req  <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_acc_byte;
    logic [15:0] r_sum;
    logic        w_oe_rise;

    assign w_oe_rise = bus.ldr_oe & ~r_oe_q;

    // The byte offered in IDLE is the one acked later, since the sender holds it until ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_acc_byte <= '0;
            r_sum      <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_take) r_acc_byte <= bus.ldr_wdat;
            if (w_oe_rise)      r_sum <= '0;
            else if (w_ack_set) r_sum <= r_sum + {8'h00, r_acc_byte};
        end
    end

    assign sum = r_sum;
`else
    assign sum = 16'h0000;
`endif

    assign busy         = (r_state != S_IDLE);
    assign bus.ldr_ack  = r_ack;
    assign bus.ldr_done = r_done;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_be   = r_mem_be;

endmodule

// File: tb/tb_pc88_loader_sink.sv
// Bench for pc88_loader_sink: loader sender, SDRAM responder and write scoreboard.
// Expected writes are queued when bytes are driven and compared on each mem_ack.
module tb_pc88_loader_sink;

    localparam int AW = 19;

    typedef struct packed {
        logic [AW-2:0] addr;
        logic [15:0]   din;
        logic [1:0]    be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] sum;

    pc88_loader_sink_if #(.AW(AW)) bus ();

    pc88_loader_sink #(
        .AW         (AW),
        .BASE_WADDR (18'h00000)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus),
        .busy    (busy),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    wr_t         sb[$];
    int          ack_delay = 0;
    int          spur_req = 0;
    int          spur_done = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          done_wr_snap = 0;
    logic [15:0] exp_sum = 16'h0000;

    // Responder state
    int          req_cycles = 0;
    bit          unstable = 1'b0;
    wr_t         cap;
    wr_t         got;
    wr_t         exp_wr;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.ldr_ack === 1'b1) ack_cnt++;
            if (bus.ldr_done === 1'b1) begin
                done_cnt++;
                done_wr_snap = wr_cnt;
            end
        end
    end

    // SDRAM arbiter model: acks after ack_delay cycles and scores each committed write.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (rst === 1'b1) begin
                req_cycles = 0;
                unstable   = 1'b0;
            end else if (bus.mem_req === 1'b1) begin
                got.addr = bus.mem_addr;
                got.din  = bus.mem_din;
                got.be   = bus.mem_be;
                if (req_cycles == 0) cap = got;
                else if (got !== cap) unstable = 1'b1;
                req_cycles++;
                if (req_cycles > ack_delay) begin
                    bus.mem_ack = 1'b1;
                    req_cycles  = 0;
                    wr_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL mem_write_unexpected got addr=%h din=%h be=%b", got.addr, got.din, got.be);
                    end else begin
                        exp_wr = sb.pop_front();
                        if (got !== exp_wr) begin
                            errors++;
                            $display("FAIL mem_write got addr=%h din=%h be=%b want addr=%h din=%h be=%b",
                                     got.addr, got.din, got.be, exp_wr.addr, exp_wr.din, exp_wr.be);
                        end
                    end
                    checks++;
                    if (unstable) begin
                        errors++;
                        $display("FAIL mem_stable addr/din/be changed while mem_req held, final addr=%h din=%h be=%b",
                                 got.addr, got.din, got.be);
                    end
                    unstable = 1'b0;
                end
            end else if (spur_done != spur_req) begin
                bus.mem_ack = 1'b1;
                spur_done++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-2:0] a, input logic [15:0] d, input logic [1:0] b);
        wr_t e;
        e.addr = a;
        e.din  = d;
        e.be   = b;
        sb.push_back(e);
    endtask

    task automatic start_session();
        @(negedge clk);
        bus.ldr_oe = 1'b1;
        exp_sum    = 16'h0000;
    endtask

    task automatic end_session();
        @(negedge clk);
        bus.ldr_oe = 1'b0;
    endtask

    // Drives one byte, waits (bounded) for ldr_ack, then holds ldr_wr extra_hold more cycles.
    task automatic send_byte(input logic [AW-1:0] adr, input logic [7:0] dat,
                             input int extra_hold, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        @(negedge clk);
        bus.ldr_adr  = adr;
        bus.ldr_wdat = dat;
        bus.ldr_wr   = 1'b1;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.ldr_ack === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout adr=%h got no ldr_ack, want one within 300 cycles", adr);
        end else begin
`ifdef LOADER_CHECKSUM_EN
            exp_sum = exp_sum + {8'h00, dat};
`endif
        end
        repeat (extra_hold) @(negedge clk);
        bus.ldr_wr = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        idle(3);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL %s ldr_done pulses got=%0d want=1", name, done_cnt - base);
        end
    endtask

    task automatic test_reset();
        string       nm[8];
        logic [17:0] gv[8];
        rst          = 1'b1;
        bus.ldr_oe   = 1'b0;
        bus.ldr_wr   = 1'b0;
        bus.ldr_adr  = '0;
        bus.ldr_wdat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        nm = '{"ldr_ack", "ldr_done", "mem_req", "mem_be", "mem_din", "mem_addr", "busy", "sum"};
        gv = '{18'(bus.ldr_ack), 18'(bus.ldr_done), 18'(bus.mem_req), 18'(bus.mem_be),
               18'(bus.mem_din), 18'(bus.mem_addr), 18'(busy), 18'(sum)};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gv[i] !== 18'h0) begin
                errors++;
                $display("FAIL reset_%s got=%h want=0", nm[i], gv[i]);
            end
        end
    endtask

    task automatic test_word_pair();
        int lat;
        int a0;
        start_session();
        idle(2);
        a0 = ack_cnt;
        expect_wr(18'h0, 16'h2211, 2'b11);
        send_byte(19'h0, 8'h11, 0, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL even_ack_latency got=%0d want=2", lat);
        end
        send_byte(19'h1, 8'h22, 0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL word_ack_latency got=%0d want=3", lat);
        end
        idle(2);
        checks++;
        if (ack_cnt - a0 != 2) begin
            errors++;
            $display("FAIL pair_ack_count got=%0d want=2", ack_cnt - a0);
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL pair_sum got=%h want=%h", sum, exp_sum);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pair_written pending writes got=%0d want=0", sb.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pair_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_end_flush();
        int lat;
        int d0;
        int w0;
        expect_wr(18'h2, 16'h00AA, 2'b01);
        send_byte(19'h4, 8'hAA, 0, lat);
        idle(2);
        d0 = done_cnt;
        w0 = wr_cnt;
        checks++;
        if (wr_cnt != w0 || sb.size() != 1) begin
            errors++;
            $display("FAIL flush_held pending writes got=%0d want=1", sb.size());
        end
        end_session();
        wait_done(d0, "flush_done");
        checks++;
        if (done_wr_snap != w0 + 1) begin
            errors++;
            $display("FAIL flush_done_order writes before done got=%0d want=%0d", done_wr_snap, w0 + 1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flush_written pending writes got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_nonseq();
        int lat;
        int a0;
        int d0;
        start_session();
        a0 = ack_cnt;
        expect_wr(18'h0, 16'h0055, 2'b01);
        expect_wr(18'h3, 16'h6600, 2'b10);
        send_byte(19'h0, 8'h55, 0, lat);
        send_byte(19'h7, 8'h66, 0, lat);
        idle(2);
        checks++;
        if (ack_cnt - a0 != 2) begin
            errors++;
            $display("FAIL nonseq_ack_count got=%0d want=2", ack_cnt - a0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL nonseq_written pending writes got=%0d want=0", sb.size());
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL nonseq_sum got=%h want=%h", sum, exp_sum);
        end
        d0 = done_cnt;
        end_session();
        idle(3);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_no_hold ldr_done pulses got=%0d want=1", done_cnt - d0);
        end
    endtask

    task automatic test_oe_low();
        int a0;
        a0 = ack_cnt;
        @(negedge clk);
        bus.ldr_adr  = 19'h0;
        bus.ldr_wdat = 8'hEE;
        bus.ldr_wr   = 1'b1;
        idle(8);
        checks++;
        if (ack_cnt != a0) begin
            errors++;
            $display("FAIL oe_low_ack got=%0d acks want=0", ack_cnt - a0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL oe_low_busy got=%b want=0", busy);
        end
        bus.ldr_wr = 1'b0;
    endtask

    task automatic test_hold_wr();
        int lat;
        int a0;
        int w0;
        start_session();
        a0 = ack_cnt;
        w0 = wr_cnt;
        expect_wr(18'h4, 16'h7700, 2'b10);
        send_byte(19'h9, 8'h77, 10, lat);
        idle(3);
        checks++;
        if (ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL hold_wr_ack_count got=%0d want=1", ack_cnt - a0);
        end
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL hold_wr_write_count got=%0d want=1", wr_cnt - w0);
        end
    endtask

    task automatic test_slow_ack();
        int lat;
        ack_delay = 50;
        expect_wr(18'h1, 16'h4433, 2'b11);
        send_byte(19'h2, 8'h33, 0, lat);
        send_byte(19'h3, 8'h44, 0, lat);
        checks++;
        if (lat !== 53) begin
            errors++;
            $display("FAIL slow_ack_latency got=%0d want=53", lat);
        end
        ack_delay = 0;
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL slow_written pending writes got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_spurious_ack();
        int lat;
        spur_req++;
        idle(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_busy got=%b want=0", busy);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_req got=%b want=0", bus.mem_req);
        end
        expect_wr(18'h2, 16'h1200, 2'b10);
        send_byte(19'h5, 8'h12, 0, lat);
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL spurious_written pending writes got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        int d0;
        ack_delay = 1000;
        send_byte(19'h0, 8'h9A, 0, lat);
        @(negedge clk);
        bus.ldr_adr  = 19'h3;
        bus.ldr_wdat = 8'hBC;
        bus.ldr_wr   = 1'b1;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req_seen got=%b want=1", bus.mem_req);
        end
        rst        = 1'b1;
        bus.ldr_wr = 1'b0;
        bus.ldr_oe = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_req got=%b want=0", bus.mem_req);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy got=%b want=0", busy);
        end
        rst       = 1'b0;
        ack_delay = 0;
        start_session();
        expect_wr(18'h0, 16'h005A, 2'b01);
        send_byte(19'h0, 8'h5A, 0, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL reset_mid_fresh_latency got=%0d want=2", lat);
        end
        idle(2);
        d0 = done_cnt;
        end_session();
        wait_done(d0, "reset_mid_done");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_written pending writes got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_pair();
        test_end_flush();
        test_nonseq();
        test_oe_low();
        test_hold_wr();
        test_slow_ack();
        test_spurious_ack();
        test_reset_mid();
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained pending writes got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc88_loader_sink.md
# pc88_loader_sink

Responder end of the ROM/disk-image loader handshake in the PC-8801 core. It accepts the byte stream driven by the MiSTer top level (`LOADER_ADR`, `LOADER_WDAT`, `LOADER_WR`, `LOADER_OE`) and returns the `LOADER_ACK` pulse that clears the sender's write request. It packs consecutive bytes into 16-bit little-endian words and issues them to the SDRAM arbiter through a request/acknowledge write port. It flushes any trailing odd byte when loading ends.

## Interface
- `BASE_WADDR`, default 18'h00000: word offset added to the packed word address.
- `AW`, default 19: byte-address width of `ldr_adr`; the word address is `AW-1` bits.
- `clk_sys` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ldr_oe` in 1: loader session active. A falling edge ends the session.
- `ldr_adr` in AW: byte address, valid while `ldr_wr`=1.
- `ldr_wdat` in 8: byte data, valid while `ldr_wr`=1.
- `ldr_wr` in 1: level request. Held high by the sender until it sees `ldr_ack` rise.
- `ldr_ack` out 1: one-cycle pulse, byte accepted.
- `ldr_done` out 1: one-cycle pulse after the end-of-session flush completes.
- `mem_req` out 1: write request, held until `mem_ack`.
- `mem_addr` out AW-1: word address, `ldr_adr[AW-1:1]`+`BASE_WADDR`.
- `mem_din` out 16: `{odd byte, even byte}`.
- `mem_be` out 2: byte enables; bit0 is the even byte.
- `mem_ack` in 1: one-cycle pulse from the arbiter, write committed.
- `busy` out 1: high in any state except IDLE.
- `sum` out 16: running byte checksum (see Configuration).

## Operation
- Holding register: `hold_data[7:0]`, `hold_waddr`, `hold_vld`.
- States: IDLE, WRITE, ACK, WAITLOW, FLUSH.
- IDLE, on `ldr_wr`=1 and `ldr_oe`=1 and `armed`=1:
  - Even address, `hold_vld`=0: latch the byte into hold, set `hold_vld`. Go to ACK.
  - Odd address with `hold_vld`=1 and `hold_waddr` equal to this word address: write `{wdat, hold_data}` with be=11. Clear `hold_vld`. Go to WRITE.
  - Any other case where `hold_vld`=1 (non-sequential address): flush the held byte with be=01 in WRITE. Stay un-acked and re-evaluate the same byte on return to IDLE.
  - Odd address with `hold_vld`=0: write `{wdat, 8'h00}` with be=10. Go to WRITE.
- WRITE: `mem_req`=1 with address, data and be stable. On `mem_ack`, drop `mem_req` the same edge.
  - If the write was a pending-byte flush, go to IDLE.
  - Otherwise go to ACK.
- ACK: `ldr_ack`=1 for exactly one cycle. Clear `armed`. Go to WAITLOW.
- WAITLOW: stay until `ldr_wr`=0, then set `armed` and go to IDLE. A byte is never accepted twice.
- Falling edge of `ldr_oe`, detected in IDLE:
  - If `hold_vld`=1: go to FLUSH and write be=01 through the WRITE handshake, then pulse `ldr_done`.
  - If `hold_vld`=0: pulse `ldr_done` the next cycle.
  - If the falling edge is seen in any other state, latch it and service it on the next entry to IDLE.
- `ldr_wr` while `ldr_oe`=0 is ignored; no ack is issued.

## Timing
- Reset values: `ldr_ack`=0, `ldr_done`=0, `mem_req`=0, `mem_be`=00, `mem_din`=0, `mem_addr`=0, `busy`=0, `sum`=0, `hold_vld`=0, `armed`=1, state IDLE.
- Reset mid-operation: `mem_req` drops on the reset edge; the arbiter tolerates an abandoned request. The held byte is lost.
- Even byte: `ldr_ack` goes high 2 cycles after `ldr_wr` is sampled high.
- Word write: `mem_req` rises 1 cycle after the sample; `ldr_ack` rises 1 cycle after `mem_ack`.
- A `mem_ack` arriving while `mem_req`=0 is ignored.
- Address wrap: word address arithmetic is modulo 2^(AW-1).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `sum` adds each accepted byte, zero-extended, modulo 2^16, on the edge where `ldr_ack` rises.
  - `sum` clears on the rising edge of `ldr_oe`.
- Undefined: `sum` is tied to 16'h0000 and the adder is not built.

## Test plan
- Bytes 0x11@0, 0x22@1 -> one `mem_req`: addr 0, din 0x2211, be 11. Two `ldr_ack` pulses. `sum`=0x0033 with the macro defined.
- Byte 0xAA@4, then `ldr_oe` falls -> write addr 2, din 0x00AA, be 01. `ldr_done` pulses once after `mem_ack`.
- Bytes 0x55@0 then 0x66@7 -> flush: addr 0, be 01. Then write addr 3, din 0x6600, be 10. Exactly 2 acks.
- `ldr_wr` held high 10 cycles after the ack -> exactly 1 `ldr_ack`, no second write.
- `mem_ack` delayed 50 cycles -> `mem_req` and data stay stable; `ldr_ack` stays 0 until after `mem_ack`.
- `reset` asserted during WRITE -> next cycle `mem_req`=0, `busy`=0. A subsequent byte @0 is handled as a fresh even byte.
